// File: rtl/dm_responder.sv
// Data-memory responder for the RV32 MEM stage: word RAM with byte/half/word
// stores, combinational extended loads, and a four-register MMIO block.
module dm_responder #(
  parameter int unsigned DEPTH_WORDS = 128,
  parameter int unsigned ADDR_W      = 7,
  parameter int unsigned GPIO_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_w,
  input  logic [2:0]        DMType,
  input  logic [31:0]       dm_addr,
  input  logic [31:0]       dm_wdata,
  output logic [31:0]       dm_rdata,
  output logic [GPIO_W-1:0] gpio_out,
  output logic              misalign_err
);

  typedef enum logic [1:0] {
    ACC_WORD,
    ACC_HALF,
    ACC_BYTE
  } acc_e;

  acc_e              acc;
  logic              sign_ext;
  logic              is_mmio;
  logic [ADDR_W-1:0] widx;
  logic [31:0]       mem_q [DEPTH_WORDS];
  logic [31:0]       rword;
  logic [15:0]       rhalf;
  logic [7:0]        rbyte;
  logic [31:0]       ram_rd;
  logic [31:0]       mmio_rd;
  logic [3:0]        be;
  logic [31:0]       wdat;
  logic              misaligned;
  logic              ram_st;
  logic              ram_we;
  logic              mmio_st;

  logic [31:0]       cyc_q, cyc_d;
  logic [31:0]       gpio_q, gpio_d;
  logic [31:0]       scnt_q, scnt_d;
  logic              sticky_q, sticky_d;

  logic              unused_addr;

  assign unused_addr = &{1'b0, dm_addr[30:ADDR_W+2]};

  assign is_mmio  = dm_addr[31];
  assign widx     = dm_addr[ADDR_W+1:2];
  assign sign_ext = (DMType == 3'b001) || (DMType == 3'b011);

  always_comb begin
    case (DMType)
      3'b001, 3'b010: acc = ACC_HALF;
      3'b011, 3'b100: acc = ACC_BYTE;
      default:        acc = ACC_WORD;
    endcase
  end

  // Store data is replicated across lanes so only the byte enables steer it.
  always_comb begin
    be         = 4'b1111;
    wdat       = dm_wdata;
    misaligned = 1'b0;
    case (acc)
      ACC_BYTE: begin
        be   = 4'b0001 << dm_addr[1:0];
        wdat = {4{dm_wdata[7:0]}};
      end
      ACC_HALF: begin
        be         = dm_addr[1] ? 4'b1100 : 4'b0011;
        wdat       = {2{dm_wdata[15:0]}};
        misaligned = dm_addr[0];
      end
      default: misaligned = |dm_addr[1:0];
    endcase
  end

  assign ram_st  = mem_w && !reset && !is_mmio;
  assign ram_we  = ram_st && !misaligned;
  assign mmio_st = mem_w && is_mmio;

  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be[i]) mem_q[widx][8*i +: 8] <= wdat[8*i +: 8];
      end
    end
  end

  assign rword = mem_q[widx];
  assign rhalf = dm_addr[1] ? rword[31:16] : rword[15:0];

  always_comb begin
    case (dm_addr[1:0])
      2'd0:    rbyte = rword[7:0];
      2'd1:    rbyte = rword[15:8];
      2'd2:    rbyte = rword[23:16];
      default: rbyte = rword[31:24];
    endcase
  end

  always_comb begin
    case (acc)
      ACC_HALF: ram_rd = {{16{sign_ext & rhalf[15]}}, rhalf};
      ACC_BYTE: ram_rd = {{24{sign_ext & rbyte[7]}}, rbyte};
      default:  ram_rd = rword;
    endcase
  end

  always_comb begin
    case (dm_addr[3:2])
      2'd0:    mmio_rd = cyc_q;
      2'd1:    mmio_rd = gpio_q;
      2'd2:    mmio_rd = {31'd0, sticky_q};
      default: mmio_rd = scnt_q;
    endcase
  end

  assign dm_rdata = is_mmio ? mmio_rd : ram_rd;

  always_comb begin
    cyc_d    = cyc_q + 32'd1;
    gpio_d   = gpio_q;
    scnt_d   = scnt_q;
    sticky_d = sticky_q;
    if (ram_we) scnt_d = scnt_q + 32'd1;
    if (ram_st && misaligned) sticky_d = 1'b1;
    if (mmio_st) begin
      case (dm_addr[3:2])
        2'd1:    gpio_d = dm_wdata;
        2'd2:    if (dm_wdata[0]) sticky_d = 1'b0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cyc_q    <= '0;
      gpio_q   <= '0;
      scnt_q   <= '0;
      sticky_q <= 1'b0;
    end else begin
      cyc_q    <= cyc_d;
      gpio_q   <= gpio_d;
      scnt_q   <= scnt_d;
      sticky_q <= sticky_d;
    end
  end

  assign gpio_out     = gpio_q[GPIO_W-1:0];
  assign misalign_err = sticky_q;

endmodule

// File: tb/tb_dm_responder.sv
// Self-checking bench for dm_responder: byte-array reference model compared
// every cycle, directed literal checks, then randomized traffic.
module tb_dm_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_w;
  logic [2:0]  DMType;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic [15:0] gpio_out;
  logic        misalign_err;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0]  mb [512];
  bit          kb [512];
  logic [31:0] m_cyc, m_gpio, m_scnt;
  bit          m_sticky;
  bit          started = 1'b0;

  always #5 clk = ~clk;

  dm_responder #(
    .DEPTH_WORDS(128),
    .ADDR_W(7),
    .GPIO_W(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .mem_w(mem_w),
    .DMType(DMType),
    .dm_addr(dm_addr),
    .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata),
    .gpio_out(gpio_out),
    .misalign_err(misalign_err)
  );

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic int acc_size(input logic [2:0] t);
    if (t == 3'd1 || t == 3'd2) return 2;
    if (t == 3'd3 || t == 3'd4) return 1;
    return 4;
  endfunction

  function automatic logic [31:0] exp_rdata(input logic [31:0] addr, input logic [2:0] t, output bit ok);
    int a, wb, n, base;
    logic [31:0] v;
    ok = 1'b1;
    if (addr[31]) begin
      case (addr[3:2])
        2'd0: return m_cyc;
        2'd1: return m_gpio;
        2'd2: return m_sticky ? 32'd1 : 32'd0;
        default: return m_scnt;
      endcase
    end
    a  = int'(addr % 512);
    wb = a - (a % 4);
    ok = kb[wb] && kb[wb+1] && kb[wb+2] && kb[wb+3];
    n  = acc_size(t);
    base = a - (a % n);
    v = 32'd0;
    for (int k = 0; k < n; k++) v = v + (32'(mb[base+k]) << (8 * k));
    if (t == 3'd1 && v[15]) v = v - 32'h0001_0000;
    if (t == 3'd3 && v[7])  v = v - 32'h0000_0100;
    return v;
  endfunction

  // Model update on each rising edge from the inputs presented that cycle
  always @(posedge clk) begin
    if (reset) begin
      m_cyc = 0; m_gpio = 0; m_scnt = 0; m_sticky = 0;
      started = 1'b1;
    end else begin
      m_cyc = m_cyc + 1;
      if (mem_w) begin
        if (dm_addr[31]) begin
          if (dm_addr[3:2] == 2'd1) m_gpio = dm_wdata;
          if (dm_addr[3:2] == 2'd2 && dm_wdata[0]) m_sticky = 0;
        end else begin
          int a, n;
          a = int'(dm_addr % 512);
          n = acc_size(DMType);
          if (a % n != 0) m_sticky = 1;
          else begin
            for (int k = 0; k < n; k++) begin
              mb[a+k] = dm_wdata[8*k +: 8];
              kb[a+k] = 1'b1;
            end
            m_scnt = m_scnt + 1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      logic [31:0] e;
      bit ok;
      chk("gpio_out", {16'd0, gpio_out}, m_gpio & 32'h0000_FFFF);
      chk("misalign_err", {31'd0, misalign_err}, {31'd0, m_sticky});
      e = exp_rdata(dm_addr, DMType, ok);
      if (ok) chk("dm_rdata", dm_rdata, e);
    end
  end

  task automatic drive(input bit w, input logic [2:0] t, input logic [31:0] a, input logic [31:0] d);
    mem_w = w; DMType = t; dm_addr = a; dm_wdata = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input bit w, input logic [2:0] t, input logic [31:0] a, input logic [31:0] d);
    drive(w, t, a, d);
    step();
  endtask

  task automatic ld(input string nm, input logic [2:0] t, input logic [31:0] a, input logic [31:0] exp);
    drive(1'b0, t, a, 32'd0);
    #1;
    chk(nm, dm_rdata, exp);
    step();
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 3'd0, 32'd0, 32'd0);
    step();
    step();
    reset = 1'b0;
    chk("rst_gpio", {16'd0, gpio_out}, 32'd0);
    chk("rst_misalign", {31'd0, misalign_err}, 32'd0);
    ld("cyc_first", 3'd0, 32'h8000_0000, 32'd0);
    repeat (9) step();
    ld("cyc_10", 3'd0, 32'h8000_0000, 32'd10);

    op(1'b1, 3'd0, 32'h40, 32'h1);
    op(1'b1, 3'd3, 32'h45, 32'h2);
    op(1'b1, 3'd1, 32'h4A, 32'h3);
    op(1'b1, 3'd0, 32'h4E, 32'h4);
    ld("scnt_3", 3'd0, 32'h8000_000C, 32'd3);
    op(1'b1, 3'd0, 32'h8000_000C, 32'h99);
    ld("scnt_ro", 3'd0, 32'h8000_000C, 32'd3);
    op(1'b1, 3'd0, 32'h8000_0008, 32'h1);

    op(1'b1, 3'd0, 32'h10, 32'h80FF_7F01);
    ld("lw_10",   3'd0, 32'h10, 32'h80FF_7F01);
    ld("lb_11",   3'd3, 32'h11, 32'h0000_007F);
    ld("lb_12",   3'd3, 32'h12, 32'hFFFF_FFFF);
    ld("lbu_12",  3'd4, 32'h12, 32'h0000_00FF);
    ld("lh_12",   3'd1, 32'h12, 32'hFFFF_80FF);
    ld("lhu_12",  3'd2, 32'h12, 32'h0000_80FF);
    ld("lb_13",   3'd3, 32'h13, 32'hFFFF_FF80);

    op(1'b1, 3'd0, 32'h20, 32'h0);
    op(1'b1, 3'd3, 32'h21, 32'h1234_56AB);
    op(1'b1, 3'd1, 32'h22, 32'hCAFE_BEEF);
    ld("partial", 3'd0, 32'h20, 32'hBEEF_AB00);
    drive(1'b1, 3'd0, 32'h20, 32'h0102_0304);
    #1;
    chk("rdw_old", dm_rdata, 32'hBEEF_AB00);
    step();
    ld("rdw_new", 3'd0, 32'h20, 32'h0102_0304);

    op(1'b1, 3'd0, 32'h30, 32'h1111_1111);
    op(1'b1, 3'd0, 32'h31, 32'hDEAD_BEEF);
    chk("mis_set", {31'd0, misalign_err}, 32'd1);
    ld("mis_sw_suppr", 3'd0, 32'h30, 32'h1111_1111);
    op(1'b1, 3'd1, 32'h33, 32'h0000_FFFF);
    ld("mis_sh_suppr", 3'd0, 32'h30, 32'h1111_1111);
    ld("scnt_9", 3'd0, 32'h8000_000C, 32'd9);
    op(1'b1, 3'd0, 32'h8000_0008, 32'h1);
    chk("mis_clr", {31'd0, misalign_err}, 32'd0);
    ld("status_0", 3'd0, 32'h8000_0008, 32'd0);

    op(1'b1, 3'd0, 32'h8000_0004, 32'h1234_ABCD);
    chk("gpio_abcd", {16'd0, gpio_out}, 32'h0000_ABCD);
    ld("gpio_rd", 3'd3, 32'h8000_0004, 32'h1234_ABCD);
    op(1'b1, 3'd0, 32'h2, 32'h5);
    chk("mis_set2", {31'd0, misalign_err}, 32'd1);
    reset = 1'b1;
    op(1'b1, 3'd0, 32'h10, 32'hFFFF_FFFF);
    reset = 1'b0;
    chk("mid_rst_gpio", {16'd0, gpio_out}, 32'd0);
    chk("mid_rst_mis", {31'd0, misalign_err}, 32'd0);
    ld("mid_rst_cyc", 3'd0, 32'h8000_0000, 32'd0);
    ld("ram_kept", 3'd0, 32'h10, 32'h80FF_7F01);

    op(1'b1, 3'd0, 32'h204, 32'h5A5A_5A5A);
    ld("wrap", 3'd0, 32'h004, 32'h5A5A_5A5A);
    op(1'b1, 3'd7, 32'h50, 32'h0BAD_F00D);
    ld("t7_lw", 3'd7, 32'h50, 32'h0BAD_F00D);
    ld("t7_lw_lowbits", 3'd7, 32'h52, 32'h0BAD_F00D);

    for (int i = 0; i < 128; i++) op(1'b1, 3'd0, 32'(i * 4), $urandom);
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] a;
      reset = ($urandom_range(0, 99) == 0);
      a = $urandom;
      if ($urandom_range(0, 4) == 0) a[31] = 1'b1;
      else begin
        a[31] = 1'b0;
        if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
      end
      drive($urandom_range(0, 2) == 0, 3'($urandom_range(0, 7)), a, $urandom);
      step();
    end
    reset = 1'b0;
    drive(1'b0, 3'd0, 32'd0, 32'd0);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
